// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the mem_inft protocol.
// Holds a 2**ADDR_W x DATA_W synchronous memory and answers read/write
// strobes. It also keeps a written flag per location, sticky read-error and
// collision flags, and saturating read/write access counters.
// Optional build macro MEM_INIT_EN: after reset the block sweeps zeros into
// every location and marks each one as written. While it does this, busy is 1.
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              rd_err,
  output logic              coll_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              sweep;
  logic [ADDR_W-1:0] sweep_ptr;
  logic              acc_wr;
  logic              acc_rd;
  logic              acc_coll;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Sticky flag update: a new error wins over a clear on the same edge.
  function automatic logic sticky_next(input logic cur, input logic set,
                                       input logic clr);
    return set ? 1'b1 : (clr ? 1'b0 : cur);
  endfunction

`ifdef MEM_INIT_EN
  typedef enum logic {IDLE, INIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;

  // State register and sweep pointer; reset restarts the sweep from location 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) ptr <= ptr + ADDR_W'(1);
    end
  end

  // Next state and sweep outputs; busy stays low while reset is held.
  always_comb begin
    state_nxt = state;
    sweep     = 1'b0;
    sweep_ptr = ptr;
    busy      = 1'b0;
    case (state)
      INIT: begin
        sweep = !reset;
        busy  = !reset;
        if (&ptr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign sweep     = 1'b0;
  assign sweep_ptr = '0;
  assign busy      = 1'b0;
`endif

  // Decode accepted accesses; a collision keeps only the write.
  always_comb begin
    acc_wr   = !busy && write;
    acc_rd   = !busy && read && !write;
    acc_coll = !busy && read && write;
    mem_we   = sweep || acc_wr;
    mem_wa   = sweep ? sweep_ptr : addr;
    mem_wd   = sweep ? '0 : data_in;
  end

  // Memory array: not reset, written by the init sweep or an accepted write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Per-location written flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) written <= '0;
    else if (mem_we) written[mem_wa] <= 1'b1;
  end

  // Registered read data; never-written locations read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else if (acc_rd) data_out <= written[addr] ? mem[addr] : '0;
  end

  // Sticky protocol-error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_err   <= 1'b0;
      coll_err <= 1'b0;
    end else begin
      rd_err   <= sticky_next(rd_err, acc_rd && !written[addr], err_clr);
      coll_err <= sticky_next(coll_err, acc_coll, err_clr);
    end
  end

  // Saturating access counters; collision reads are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (acc_wr) wr_count <= sat_inc(wr_count);
      if (acc_rd) rd_count <= sat_inc(rd_count);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Checks the outputs against a behavioural model
// of the memory, the written flags, the sticky flags and the counters.
// A second instance built with CNT_W=4 shares the same inputs, and its
// counters are checked for saturation.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       err_clr = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] data_in = '0;

  logic [7:0]  data_out;
  logic        busy, rd_err, coll_err;
  logic [15:0] wr_count, rd_count;

  logic [7:0] s_data_out;
  logic       s_busy, s_rd_err, s_coll_err;
  logic [3:0] s_wr_count, s_rd_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] ref_mem [32];
  bit         ref_written [32];
  logic [7:0] exp_dout;
  bit         exp_rd_err, exp_coll;
  int         exp_wr, exp_rd;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .busy(busy), .rd_err(rd_err),
    .coll_err(coll_err), .err_clr(err_clr), .wr_count(wr_count),
    .rd_count(rd_count)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(s_data_out), .busy(s_busy), .rd_err(s_rd_err),
    .coll_err(s_coll_err), .err_clr(err_clr), .wr_count(s_wr_count),
    .rd_count(s_rd_count)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
`ifdef MEM_INIT_EN
      ref_written[i] = 1'b1;
      ref_mem[i]     = 8'h00;
`else
      ref_written[i] = 1'b0;
`endif
    end
    exp_dout = 8'h00; exp_rd_err = 1'b0; exp_coll = 1'b0;
    exp_wr = 0; exp_rd = 0;
  endtask

  task automatic model_step(input bit r, input bit w, input bit c,
                            input logic [4:0] a, input logic [7:0] d);
    bit new_rd_err;
    new_rd_err = r && !w && !ref_written[a];
    if (w) begin
      ref_mem[a] = d;
      ref_written[a] = 1'b1;
      if (exp_wr < 65535) exp_wr++;
    end else if (r) begin
      exp_dout = ref_written[a] ? ref_mem[a] : 8'h00;
      if (exp_rd < 65535) exp_rd++;
    end
    exp_rd_err = new_rd_err ? 1'b1 : (c ? 1'b0 : exp_rd_err);
    exp_coll   = (r && w)   ? 1'b1 : (c ? 1'b0 : exp_coll);
  endtask

  // One access cycle: drive, let the edge happen, update model, sample at negedge.
  task automatic do_cycle(input bit r, input bit w, input bit c,
                          input logic [4:0] a, input logic [7:0] d);
    read = r; write = w; err_clr = c; addr = a; data_in = d;
    @(posedge clk);
    model_step(r, w, c, a, d);
    @(negedge clk);
    read = 1'b0; write = 1'b0; err_clr = 1'b0;
  endtask

  task automatic reset_dut();
    int n;
    @(negedge clk);
    reset = 1'b1; read = 1'b0; write = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_release got=%b want=0 after %0d clks", busy, n);
    end
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    do_cycle(0, 1, 0, 5'h03, 8'hA5);
    do_cycle(1, 0, 0, 5'h03, 8'h00);
    do_cycle(1, 0, 0, 5'h1F, 8'h00);
    do_cycle(1, 1, 0, 5'h04, 8'h66);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks += 7;
    if (data_out !== 8'h00) begin failures++; $display("FAIL async_reset_dout got=%h want=00", data_out); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL async_reset_busy got=%b want=0", busy); end
    if (rd_err !== 1'b0)    begin failures++; $display("FAIL async_reset_rd_err got=%b want=0", rd_err); end
    if (coll_err !== 1'b0)  begin failures++; $display("FAIL async_reset_coll got=%b want=0", coll_err); end
    if (wr_count !== 16'd0) begin failures++; $display("FAIL async_reset_wr got=%0d want=0", wr_count); end
    if (rd_count !== 16'd0) begin failures++; $display("FAIL async_reset_rd got=%0d want=0", rd_count); end
    if (s_wr_count !== 4'd0) begin failures++; $display("FAIL async_reset_sat_wr got=%0d want=0", s_wr_count); end
    reset_dut();
    // Written flags must be cleared: location 3 behaves as never written.
    do_cycle(1, 0, 0, 5'h03, 8'h00);
    checks += 2;
    if (data_out !== exp_dout) begin failures++; $display("FAIL reset_flags_dout got=%h want=%h", data_out, exp_dout); end
    if (rd_err !== exp_rd_err) begin failures++; $display("FAIL reset_flags_rd_err got=%b want=%b", rd_err, exp_rd_err); end
  endtask

  task automatic test_basic();
    reset_dut();
    do_cycle(0, 1, 0, 5'h03, 8'hA5);
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL write_holds_dout got=%h want=00", data_out); end
    do_cycle(1, 0, 0, 5'h03, 8'h00);
    checks += 4;
    if (data_out !== 8'hA5) begin failures++; $display("FAIL basic_rdata got=%h want=a5", data_out); end
    if (wr_count !== 16'd1) begin failures++; $display("FAIL basic_wr_count got=%0d want=1", wr_count); end
    if (rd_count !== 16'd1) begin failures++; $display("FAIL basic_rd_count got=%0d want=1", rd_count); end
    if (rd_err !== 1'b0)    begin failures++; $display("FAIL basic_rd_err got=%b want=0", rd_err); end
    repeat (3) do_cycle(0, 0, 0, 5'h03, 8'h00);
    checks++;
    if (data_out !== 8'hA5) begin failures++; $display("FAIL idle_hold_dout got=%h want=a5", data_out); end
  endtask

  task automatic test_unwritten();
    reset_dut();
`ifdef MEM_INIT_EN
    do_cycle(1, 0, 0, 5'h10, 8'h00);
    checks += 2;
    if (data_out !== 8'h00) begin failures++; $display("FAIL init_read_dout got=%h want=00", data_out); end
    if (rd_err !== 1'b0)    begin failures++; $display("FAIL init_read_rd_err got=%b want=0", rd_err); end
`else
    do_cycle(0, 1, 0, 5'h1E, 8'h77);
    do_cycle(1, 0, 0, 5'h1E, 8'h00);
    do_cycle(1, 0, 0, 5'h1F, 8'h00);
    checks += 2;
    if (data_out !== 8'h00) begin failures++; $display("FAIL unwritten_dout got=%h want=00", data_out); end
    if (rd_err !== 1'b1)    begin failures++; $display("FAIL unwritten_rd_err got=%b want=1", rd_err); end
    do_cycle(0, 0, 0, 5'h00, 8'h00);
    checks++;
    if (rd_err !== 1'b1) begin failures++; $display("FAIL rd_err_sticky got=%b want=1", rd_err); end
    do_cycle(0, 0, 1, 5'h00, 8'h00);
    checks++;
    if (rd_err !== 1'b0) begin failures++; $display("FAIL rd_err_clear got=%b want=0", rd_err); end
    do_cycle(1, 0, 1, 5'h1F, 8'h00);
    checks += 2;
    if (rd_err !== 1'b1)    begin failures++; $display("FAIL rd_err_set_wins got=%b want=1", rd_err); end
    if (rd_count !== 16'd3) begin failures++; $display("FAIL unwritten_rd_count got=%0d want=3", rd_count); end
`endif
  endtask

  task automatic test_collision();
    reset_dut();
    do_cycle(0, 1, 0, 5'h02, 8'h9E);
    do_cycle(1, 0, 0, 5'h02, 8'h00);
    do_cycle(1, 1, 0, 5'h07, 8'h3C);
    checks += 4;
    if (data_out !== 8'h9E) begin failures++; $display("FAIL coll_dout_hold got=%h want=9e", data_out); end
    if (coll_err !== 1'b1)  begin failures++; $display("FAIL coll_err_set got=%b want=1", coll_err); end
    if (wr_count !== 16'd2) begin failures++; $display("FAIL coll_wr_count got=%0d want=2", wr_count); end
    if (rd_count !== 16'd1) begin failures++; $display("FAIL coll_rd_count got=%0d want=1", rd_count); end
    do_cycle(1, 0, 0, 5'h07, 8'h00);
    checks += 3;
    if (data_out !== 8'h3C) begin failures++; $display("FAIL coll_readback got=%h want=3c", data_out); end
    if (rd_count !== 16'd2) begin failures++; $display("FAIL coll_rd_after got=%0d want=2", rd_count); end
    if (coll_err !== 1'b1)  begin failures++; $display("FAIL coll_err_sticky got=%b want=1", coll_err); end
    do_cycle(1, 1, 1, 5'h08, 8'h01);
    checks++;
    if (coll_err !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b want=1", coll_err); end
    do_cycle(0, 0, 1, 5'h00, 8'h00);
    checks++;
    if (coll_err !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b want=0", coll_err); end
  endtask

  task automatic test_fill_all();
    logic [7:0] want;
    reset_dut();
    for (int i = 0; i < 32; i++) do_cycle(0, 1, 0, 5'(i), 8'(i) ^ 8'h5A);
    for (int i = 31; i >= 0; i--) begin
      do_cycle(1, 0, 0, 5'(i), 8'h00);
      want = 8'(i) ^ 8'h5A;
      checks++;
      if (data_out !== want) begin failures++; $display("FAIL fill_read[%0d] got=%h want=%h", i, data_out, want); end
    end
    checks += 4;
    if (wr_count !== 16'd32) begin failures++; $display("FAIL fill_wr_count got=%0d want=32", wr_count); end
    if (rd_count !== 16'd32) begin failures++; $display("FAIL fill_rd_count got=%0d want=32", rd_count); end
    if (rd_err !== 1'b0)     begin failures++; $display("FAIL fill_rd_err got=%b want=0", rd_err); end
    if (coll_err !== 1'b0)   begin failures++; $display("FAIL fill_coll got=%b want=0", coll_err); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      do_cycle(0, 1, 0, a, d);
      do_cycle(1, 0, 0, a, 8'h00);
      checks++;
      if (data_out !== d) begin failures++; $display("FAIL b2b_read[%0d] addr=%h got=%h want=%h", k, a, data_out, d); end
    end
  endtask

  task automatic test_random();
    bit r, w, c;
    logic [3:0] sw, sr;
    reset_dut();
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 99) < 50);
      w = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 10);
      do_cycle(r, w, c, 5'($urandom_range(0, 7)), 8'($urandom));
      sw = (exp_wr > 15) ? 4'hF : 4'(exp_wr);
      sr = (exp_rd > 15) ? 4'hF : 4'(exp_rd);
      checks++;
      if (data_out !== exp_dout || rd_err !== exp_rd_err || coll_err !== exp_coll ||
          wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd) || busy !== 1'b0 ||
          s_wr_count !== sw || s_rd_count !== sr || s_data_out !== exp_dout ||
          s_rd_err !== exp_rd_err || s_coll_err !== exp_coll || s_busy !== 1'b0) begin
        failures++;
        $display("FAIL random[%0d] got dout=%h re=%b ce=%b wc=%0d rc=%0d sw=%0d sr=%0d want dout=%h re=%b ce=%b wc=%0d rc=%0d sw=%0d sr=%0d",
                 k, data_out, rd_err, coll_err, wr_count, rd_count, s_wr_count, s_rd_count,
                 exp_dout, exp_rd_err, exp_coll, exp_wr, exp_rd, sw, sr);
      end
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      do_cycle(0, 1, 0, 5'(k), 8'(k));
      if (k == 14 || k == 15 || k == 19) begin
        checks++;
        if (s_wr_count !== 4'hF) begin failures++; $display("FAIL sat_wr[%0d] got=%h want=f", k, s_wr_count); end
      end
    end
    checks++;
    if (wr_count !== 16'd20) begin failures++; $display("FAIL sat_main_wr got=%0d want=20", wr_count); end
    for (int k = 0; k < 20; k++) do_cycle(1, 0, 0, 5'(k), 8'h00);
    checks += 2;
    if (s_rd_count !== 4'hF) begin failures++; $display("FAIL sat_rd got=%h want=f", s_rd_count); end
    if (rd_count !== 16'd20) begin failures++; $display("FAIL sat_main_rd got=%0d want=20", rd_count); end
  endtask

`ifdef MEM_INIT_EN
  task automatic test_init();
    int n;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    write = 1'b1; addr = 5'h03; data_in = 8'hFF;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 64) begin @(negedge clk); n++; end
    write = 1'b0;
    checks += 2;
    if (n != 32) begin failures++; $display("FAIL init_busy_len got=%0d want=32", n); end
    if (wr_count !== 16'd0) begin failures++; $display("FAIL init_ignored_wr got=%0d want=0", wr_count); end
    model_reset();
    do_cycle(1, 0, 0, 5'h03, 8'h00);
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL init_ignored_data got=%h want=00", data_out); end
    // Abort a sweep with reset at cycle 10.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL init_abort_busy got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n != 32) begin failures++; $display("FAIL init_restart_len got=%0d want=32", n); end
    model_reset();
    do_cycle(1, 0, 0, 5'h10, 8'h00);
    checks += 2;
    if (data_out !== 8'h00) begin failures++; $display("FAIL init_r10_dout got=%h want=00", data_out); end
    if (rd_err !== 1'b0)    begin failures++; $display("FAIL init_r10_rd_err got=%b want=0", rd_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_unwritten();
    test_collision();
    test_fill_all();
    test_back_to_back();
    test_random();
    test_saturation();
`ifdef MEM_INIT_EN
    test_init();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
